// File: rtl/skew_pkg.sv
// Shared definitions for the skew delay array.
// Holds the per-lane depth rule, the total stage count and the lane entry layout.
// Configuration macro: SKEW_DELAY_REVERSE_EN selects the de-skew direction, in
// which the last lane is the shortest and lane 0 the longest.
package skew_pkg;

    // Reference {valid, data} layout. Lanes flatten entries in this same
    // ordering (valid in the MSB) at their own DATA_WIDTH.
    localparam int unsigned LANE_DATA_WIDTH = 32;

    typedef struct packed {
        logic                       valid;
        logic [LANE_DATA_WIDTH-1:0] data;
    } lane_entry_t;

    // Delay of one lane in advancing cycles.
    function automatic int unsigned lane_depth(input int unsigned lane,
                                               input int unsigned num_lanes,
                                               input int unsigned base_depth,
                                               input int unsigned skew_step);
`ifdef SKEW_DELAY_REVERSE_EN
        return base_depth + (num_lanes - 1 - lane) * skew_step;
`else
        return (lane < num_lanes) ? base_depth + lane * skew_step : base_depth;
`endif
    endfunction

    // Sum of all lane depths; sizes the in-flight counter.
    function automatic int unsigned total_stages(input int unsigned num_lanes,
                                                 input int unsigned base_depth,
                                                 input int unsigned skew_step);
        int unsigned sum;
        sum = 0;
        for (int unsigned i = 0; i < num_lanes; i++) begin
            sum += lane_depth(i, num_lanes, base_depth, skew_step);
        end
        return sum;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// Single lane of the skew delay array: a DEPTH-stage {valid, data} shift chain.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset (clears all)
//   advance       shift enable; 0 holds every stage
//   flush         clears valid bits only, priority over advance
//   in_entry      {valid, data} loaded into stage 0 on an advancing edge
//   out_entry     {valid, data} of the last stage
module skew_lane #(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  flush,
    input  logic [DATA_WIDTH:0]   in_entry,
    output logic [DATA_WIDTH:0]   out_entry
);

    logic                  valid_q [DEPTH];
    logic                  valid_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_d  [DEPTH];

    // Next-state of the chain: flush drops valids but keeps data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                valid_d[k] = 1'b0;
            end
        end else if (advance) begin
            valid_d[0] = in_entry[DATA_WIDTH];
            data_d[0]  = in_entry[DATA_WIDTH-1:0];
            for (int unsigned k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_entry = {valid_q[DEPTH-1], data_q[DEPTH-1]};

endmodule

// File: rtl/skew_delay_array.sv
// Multi-lane skewing delay buffer placed at the systolic array edge.
// Lane i delays its operand by lane_depth(i) advancing cycles so the wavefront
// reaches successive PE rows one step apart. Tracks stored valid entries.
// Configuration macro: SKEW_DELAY_REVERSE_EN (de-skew direction, see skew_pkg).
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   advance       global shift enable (0 = stall, inputs ignored)
//   flush         clears all valid bits and the in-flight count
//   valid_in      per-lane input valid
//   data_in       lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_out     per-lane valid from each lane's last stage
//   data_out      per-lane payload, same packing as data_in
//   inflight      number of valid entries currently stored
//   empty         high when inflight is zero
module skew_delay_array
    import skew_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LANES  = 8,
    parameter int unsigned BASE_DEPTH = 1,
    parameter int unsigned SKEW_STEP  = 1,
    localparam int unsigned TOTAL_STAGES = total_stages(NUM_LANES, BASE_DEPTH, SKEW_STEP),
    localparam int unsigned CNT_W        = $clog2(TOTAL_STAGES + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            advance,
    input  logic                            flush,
    input  logic [NUM_LANES-1:0]            valid_in,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
    output logic [NUM_LANES-1:0]            valid_out,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
    output logic [CNT_W-1:0]                inflight,
    output logic                            empty
);

    logic [DATA_WIDTH:0] lane_out [NUM_LANES];
    logic [CNT_W-1:0]    pop_in_c;
    logic [CNT_W-1:0]    pop_out_c;
    logic [CNT_W-1:0]    inflight_q;
    logic [CNT_W-1:0]    inflight_d;
    logic                empty_q;
    logic                empty_d;

    // One delay chain per lane, depth taken from the shared depth rule.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int unsigned DEPTH = lane_depth(i, NUM_LANES, BASE_DEPTH, SKEW_STEP);

        skew_lane #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .flush     (flush),
            .in_entry  ({valid_in[i], data_in[i*DATA_WIDTH +: DATA_WIDTH]}),
            .out_entry (lane_out[i])
        );

        assign valid_out[i]                          = lane_out[i][DATA_WIDTH];
        assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = lane_out[i][DATA_WIDTH-1:0];
    end

    // Entries accepted minus entries consumed on an advancing edge. The sum is
    // modular but the final value always fits, since it is bounded by TOTAL_STAGES.
    always_comb begin
        pop_in_c  = '0;
        pop_out_c = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            pop_in_c  = pop_in_c  + CNT_W'(valid_in[i]);
            pop_out_c = pop_out_c + CNT_W'(valid_out[i]);
        end
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (advance) begin
            inflight_d = inflight_q + pop_in_c - pop_out_c;
        end
        empty_d = (inflight_d == '0);
    end

    // Counter and empty flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            empty_q    <= 1'b1;
        end else begin
            inflight_q <= inflight_d;
            empty_q    <= empty_d;
        end
    end

    assign inflight = inflight_q;
    assign empty    = empty_q;

endmodule

// File: tb/tb_skew_delay_array.sv
// Self-checking bench for skew_delay_array (4 lanes, 8-bit data, delays 1..4).
// A queue-per-lane delay model predicts every output each cycle.
module tb_skew_delay_array;

    localparam int NL = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              advance = 1'b0;
    logic              flush = 1'b0;
    logic [NL-1:0]     valid_in = '0;
    logic [NL*DW-1:0]  data_in = '0;
    logic [NL-1:0]     valid_out;
    logic [NL*DW-1:0]  data_out;
    logic [3:0]        inflight;
    logic              empty;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    skew_delay_array #(
        .DATA_WIDTH (DW),
        .NUM_LANES  (NL),
        .BASE_DEPTH (1),
        .SKEW_STEP  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .flush     (flush),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .inflight  (inflight),
        .empty     (empty)
    );

    // ---------------- reference model ----------------
    typedef struct { bit v; bit [DW-1:0] d; } ent_t;
    ent_t lq [NL][$];

    function automatic int depth_of(int lane);
`ifdef SKEW_DELAY_REVERSE_EN
        return 1 + (NL - 1 - lane);
`else
        return 1 + lane;
`endif
    endfunction

    task automatic model_reset();
        ent_t z;
        z.v = 0;
        z.d = '0;
        for (int i = 0; i < NL; i++) begin
            lq[i].delete();
            for (int k = 0; k < depth_of(i); k++) lq[i].push_back(z);
        end
    endtask

    task automatic model_edge();
        ent_t e;
        if (rst) begin
            model_reset();
        end else if (flush) begin
            for (int i = 0; i < NL; i++)
                for (int k = 0; k < lq[i].size(); k++) lq[i][k].v = 0;
        end else if (advance) begin
            for (int i = 0; i < NL; i++) begin
                e.v = valid_in[i];
                e.d = data_in[i*DW +: DW];
                lq[i].push_front(e);
                void'(lq[i].pop_back());
            end
        end
    endtask

    function automatic logic [NL-1:0] exp_vout();
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) r[i] = lq[i][lq[i].size()-1].v;
        return r;
    endfunction

    function automatic logic [NL*DW-1:0] exp_dout();
        logic [NL*DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = lq[i][lq[i].size()-1].d;
        return r;
    endfunction

    function automatic logic [3:0] exp_inflight();
        int n = 0;
        for (int i = 0; i < NL; i++)
            for (int k = 0; k < lq[i].size(); k++) n += int'(lq[i][k].v);
        return 4'(n);
    endfunction

    // Drive one cycle, advance the model at the edge, sample 1 time unit later.
    task automatic step(bit r, bit f, bit a, logic [NL-1:0] v, logic [NL*DW-1:0] d);
        rst = r; flush = f; advance = a; valid_in = v; data_in = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(1, 0, 0, '0, '0);
        step(1, 0, 1, 4'hF, 32'hDEADBEEF);
        checks++;
        if (valid_out !== 4'b0000 || data_out !== '0 || inflight !== 4'd0 || empty !== 1'b1)
            $display("FAIL reset: got v=%b d=%h infl=%0d empty=%b, want v=0000 d=0 infl=0 empty=1",
                     valid_out, data_out, inflight, empty);
        else passed++;
        step(0, 0, 0, '0, '0);
    endtask

    task automatic test_wavefront();
        int lane;
        step(0, 0, 1, 4'hF, 32'h13121110);
        checks++;
        if (inflight !== 4'd4) $display("FAIL wave_peak: inflight got %0d want 4", inflight);
        else passed++;
        for (int n = 0; n < 6; n++) begin
            checks++;
            if (valid_out !== exp_vout() || data_out !== exp_dout() ||
                inflight !== exp_inflight() || empty !== (exp_inflight() == 0))
                $display("FAIL wave_model n=%0d: got v=%b d=%h infl=%0d e=%b want v=%b d=%h infl=%0d",
                         n, valid_out, data_out, inflight, empty, exp_vout(), exp_dout(), exp_inflight());
            else passed++;
            if (n < NL) begin
`ifdef SKEW_DELAY_REVERSE_EN
                lane = NL - 1 - n;
`else
                lane = n;
`endif
                checks++;
                if (valid_out !== 4'(1 << lane) || data_out[lane*DW +: DW] !== 8'(8'h10 + lane))
                    $display("FAIL wave_order n=%0d: got v=%b lane%0d=%h want v=%b data=%h",
                             n, valid_out, lane, data_out[lane*DW +: DW], 4'(1 << lane), 8'(8'h10 + lane));
                else passed++;
            end
            step(0, 0, 1, 4'h0, 32'($urandom));
        end
        checks++;
        if (inflight !== 4'd0 || empty !== 1'b1)
            $display("FAIL wave_drain: got infl=%0d empty=%b want 0/1", inflight, empty);
        else passed++;
    endtask

    task automatic test_stall();
        logic [NL-1:0]    sv;
        logic [NL*DW-1:0] sd;
        step(0, 0, 1, 4'hF, 32'h23222120);
        step(0, 0, 1, 4'h0, 32'h0);
        sv = valid_out;
        sd = data_out;
        for (int s = 0; s < 3; s++) begin
            step(0, 0, 0, 4'($urandom), 32'($urandom));
            checks++;
            if (valid_out !== sv || data_out !== sd || inflight !== exp_inflight())
                $display("FAIL stall_hold s=%0d: got v=%b d=%h infl=%0d want v=%b d=%h infl=%0d",
                         s, valid_out, data_out, inflight, sv, sd, exp_inflight());
            else passed++;
        end
        for (int n = 0; n < 5; n++) begin
            step(0, 0, 1, 4'h0, 32'($urandom));
            checks++;
            if (valid_out !== exp_vout() || data_out !== exp_dout() || inflight !== exp_inflight())
                $display("FAIL stall_resume n=%0d: got v=%b d=%h infl=%0d want v=%b d=%h infl=%0d",
                         n, valid_out, data_out, inflight, exp_vout(), exp_dout(), exp_inflight());
            else passed++;
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                step(0, 1, 1, 4'hF, 32'hF3F2F1F0);
                checks++;
                if (valid_out !== 4'b0000 || inflight !== 4'd0 || empty !== 1'b1)
                    $display("FAIL flush_clear: got v=%b infl=%0d empty=%b want 0000/0/1",
                             valid_out, inflight, empty);
                else passed++;
            end else begin
                step(0, 0, 1, 4'hF, {8'(8'h30 + c), 8'(8'h30 + c), 8'(8'h30 + c), 8'(8'h30 + c)});
            end
        end
        for (int n = 0; n < 6; n++) begin
            step(0, 0, 1, 4'h0, 32'h0);
            checks++;
            if (valid_out !== exp_vout() || data_out !== exp_dout() || inflight !== exp_inflight())
                $display("FAIL flush_drain n=%0d: got v=%b d=%h infl=%0d want v=%b d=%h infl=%0d",
                         n, valid_out, data_out, inflight, exp_vout(), exp_dout(), exp_inflight());
            else passed++;
            for (int i = 0; i < NL; i++) begin
                checks++;
                if (valid_out[i] && data_out[i*DW +: DW] == 8'(8'hF0 + i))
                    $display("FAIL flush_leak lane%0d: got flushed data %h with valid", i, data_out[i*DW +: DW]);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 0, '0, '0);
        for (int c = 0; c < 16; c++) begin
            step(0, 0, 1, 4'hF, 32'($urandom));
            checks++;
            if (valid_out !== exp_vout() || data_out !== exp_dout() || inflight !== exp_inflight())
                $display("FAIL steady_model c=%0d: got v=%b d=%h infl=%0d want v=%b d=%h infl=%0d",
                         c, valid_out, data_out, inflight, exp_vout(), exp_dout(), exp_inflight());
            else passed++;
            if (c >= 3) begin
                checks++;
                if (inflight !== 4'd10 || empty !== 1'b0)
                    $display("FAIL steady_full c=%0d: got infl=%0d empty=%b want 10/0", c, inflight, empty);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            r = int'($urandom_range(0, 99));
            step(r < 2, (r >= 2 && r < 7), ($urandom_range(0, 3) != 0), 4'($urandom), 32'($urandom));
            checks++;
            if (valid_out !== exp_vout() || data_out !== exp_dout() ||
                inflight !== exp_inflight() || empty !== (exp_inflight() == 0))
                $display("FAIL random c=%0d: got v=%b d=%h infl=%0d e=%b want v=%b d=%h infl=%0d",
                         c, valid_out, data_out, inflight, empty, exp_vout(), exp_dout(), exp_inflight());
            else passed++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_wavefront();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/skew_delay_array.md
Name: skew_delay_array

Overview:
- Multi-lane, parameterised delay-line buffer that skews operand vectors entering the systolic array.
- Lane i delays its data by its own number of cycles, so the wavefront reaches each PE row or column one step later than the lane before it.
- Adds over a fixed single-lane delay line: global advance/stall, flush, per-lane valid tracking, an in-flight counter and an empty flag.
- Sits between the operand staging buffers and the array edge.

Parameters:
- DATA_WIDTH, 32, payload bits per lane.
- NUM_LANES, 8, number of independent lanes; must be >= 1.
- BASE_DEPTH, 1, delay of lane 0 in advancing cycles; must be >= 1.
- SKEW_STEP, 1, additional delay per lane index; must be >= 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- advance  in  1  shift enable; 0 = stall, so all stages hold and inputs are ignored.
- flush  in  1  synchronous clear of all valid bits.
- valid_in  in  NUM_LANES  per-lane input valid.
- data_in  in  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_out  out  NUM_LANES  per-lane output valid, taken from the last stage of each lane.
- data_out  out  NUM_LANES*DATA_WIDTH  per-lane output payload, same packing as data_in.
- inflight  out  $clog2(TOTAL_STAGES+1)  number of valid entries currently stored.
- empty  out  1  high when inflight == 0.

Behaviour:
- Lane depth: D(i) = BASE_DEPTH + i*SKEW_STEP. TOTAL_STAGES = sum of D(i) over all lanes.
- Each lane is a D(i)-stage register chain. Each stage stores {valid, data}.
- Outputs are driven directly from the last stage of each lane. There is no combinational path from the inputs to the outputs.
- Advance = 1 at an edge:
  - Stage 0 of lane i loads {valid_in[i], data_in[i]}.
  - Stage k loads stage k-1.
  - A sample accepted at edge t appears on lane i's outputs after edge t+D(i)-1 and stays valid until the next advancing edge.
  - With BASE_DEPTH=1, lane 0 shows the sample in the cycle after acceptance.
- Advance = 0: every stage holds its value, the outputs hold, and valid_in and data_in are ignored.
- Consumption: an output entry counts as consumed at an edge where advance=1 and its valid_out bit is 1.
- inflight update each advancing edge:
  - next = inflight + popcount(valid_in) - popcount(valid_out).
  - Both terms are applied in the same cycle.
  - The counter never wraps, because its width covers TOTAL_STAGES.
- Flush:
  - Clears every valid bit and sets inflight to 0. Data bits are left unchanged.
  - Flush has priority over advance; inputs presented in a flush cycle are dropped.
- Reset:
  - Same as flush, and additionally clears all data bits to 0.
  - Takes priority over flush and advance.
  - Reset values: valid_out = 0, data_out = 0, inflight = 0, empty = 1.
  - Reset asserted mid-stream discards all in-flight entries at that edge.
- Lanes with valid_in=0 still shift. Bubbles propagate and are not counted in inflight.
- Lanes are fully independent apart from the shared advance, flush and rst.
- SKEW_STEP=0 gives a uniform delay of BASE_DEPTH on every lane.

Optional Feature:
- Macro: SKEW_DELAY_REVERSE_EN.
- Defined: D(i) = BASE_DEPTH + (NUM_LANES-1-i)*SKEW_STEP. This is the de-skew direction, used on the array output edge to realign result vectors.
- Undefined: the forward skew formula above applies.
- TOTAL_STAGES, inflight width and all other behaviour are identical in both modes.

Decomposition:
- Shared package skew_pkg holds:
  - function lane_depth(i, NUM_LANES, BASE_DEPTH, SKEW_STEP), which honours the macro;
  - function total_stages(...);
  - typedef lane_entry_t = struct {valid, data}.
- One sub-module, skew_lane:
  - parameters DEPTH and DATA_WIDTH;
  - ports clk, rst, advance, flush, in entry, out entry.
- The top level generates NUM_LANES instances of skew_lane and adds the popcount logic and the inflight counter.

Test Plan (NUM_LANES=4, BASE_DEPTH=1, SKEW_STEP=1, DATA_WIDTH=8, so delays are 1,2,3,4 and TOTAL_STAGES=10):
- Reset: hold rst for 2 cycles -> valid_out=0000, data_out all 0, inflight=0, empty=1.
- Single wavefront: valid_in=1111 with data 0x10,0x11,0x12,0x13, one advancing cycle, then continuous advance with valid_in=0 -> lane i outputs 0x10+i exactly i cycles after lane 0. inflight peaks at 4 and reaches 0 (empty=1) after the fourth advancing edge.
- Stall: same wavefront, advance=0 for 3 cycles after the second edge -> outputs frozen for those 3 cycles, inputs applied during the stall do not appear, each lane's output timing is shifted by exactly 3 cycles.
- Flush mid-stream: stream 5 full vectors, assert flush together with valid_in=1111 on cycle 3 -> valid_out=0000 on the next cycle, inflight=0, and no flushed-cycle data ever emerges.
- Simultaneous in/out: steady stream with valid_in=1111 every cycle -> once full, inflight holds at 10 with the +4 and -4 terms balanced, and empty stays 0.
- Reverse mode, compiled with SKEW_DELAY_REVERSE_EN: same wavefront as the single-wavefront test -> lane 3 emerges first (delay 1) and lane 0 last (delay 4).
